// File: rtl/pc_trace_monitor.sv
// Purpose: observes the core PC, keeps a circular trace of the last DEPTH distinct PCs, counts cycles/changes, detects halt idiom.
// Latency: all outputs registered, update on the edge after the causing sample; rd_pc is 1 cycle behind rd_idx.
// Backpressure: none; pure observer, en=0 freezes all state while the read port keeps working.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset (overrides everything)
//   pc, en          sampled program counter and sample enable
//   rd_idx, rd_pc   trace read index (0 = newest) and registered entry (0 if index not valid)
//   trace_count     number of valid entries, saturates at DEPTH
//   overflow        sticky, set when an old entry is overwritten
//   cycle_count     enabled sampled cycles since reset, saturating
//   change_count    PC changes since the first sample, saturating
//   halted, halt_pc halt detected (PC stuck for HALT_CYCLES samples) and the PC it stuck at
module pc_trace_monitor #(
  parameter int DEPTH       = 16,
  parameter int HALT_CYCLES = 8,
  parameter int CNT_W       = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [31:0]                pc,
  input  logic                       en,
  input  logic [$clog2(DEPTH)-1:0]   rd_idx,
  output logic [31:0]                rd_pc,
  output logic [$clog2(DEPTH):0]     trace_count,
  output logic                       overflow,
  output logic [CNT_W-1:0]           cycle_count,
  output logic [CNT_W-1:0]           change_count,
  output logic                       halted,
  output logic [31:0]                halt_pc
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(HALT_CYCLES + 1);

  localparam logic [AW-1:0]    PTR_ONE = AW'(1);
  localparam logic [AW:0]      TC_ONE  = (AW + 1)'(1);
  localparam logic [AW:0]      TC_FULL = (AW + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [SW-1:0]    ST_ONE  = SW'(1);
  localparam logic [SW-1:0]    ST_HALT = SW'(HALT_CYCLES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t          state;
  logic [31:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [31:0]     prev_pc;
  logic [SW-1:0]   stable_cnt;

  logic            pc_change;
  logic            wr_en;
  logic [AW-1:0]   rd_addr;
  logic            rd_hit;
  logic [SW-1:0]   stable_nxt;

  assign pc_change  = (pc != prev_pc);
  // First sample out of IDLE always writes; afterwards only distinct PCs do.
  assign wr_en      = en && !rst && ((state == IDLE) || pc_change);
  // Newest entry lives at wr_ptr-1; index walks backwards, wrapping mod DEPTH.
  assign rd_addr    = wr_ptr - PTR_ONE - rd_idx;
  assign rd_hit     = ({1'b0, rd_idx} < trace_count);
  assign stable_nxt = stable_cnt + ST_ONE;

  // Trace storage has no reset; trace_count gates what the read port exposes.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      trace_count  <= '0;
      overflow     <= 1'b0;
      cycle_count  <= '0;
      change_count <= '0;
      halted       <= 1'b0;
      halt_pc      <= '0;
      prev_pc      <= '0;
      stable_cnt   <= '0;
      rd_pc        <= '0;
    end else begin
      // Read uses pre-write pointer/contents, so a same-cycle write is not visible yet.
      rd_pc <= rd_hit ? mem[rd_addr] : '0;

      if (en) begin
        case (state)
          IDLE: begin
            wr_ptr      <= PTR_ONE;
            trace_count <= TC_ONE;
            prev_pc     <= pc;
            stable_cnt  <= '0;
            cycle_count <= CNT_ONE;
            state       <= RUN;
          end

          RUN, HALTED: begin
            if (cycle_count != '1) begin
              cycle_count <= cycle_count + CNT_ONE;
            end
            if (pc_change) begin
              wr_ptr <= wr_ptr + PTR_ONE;
              if (trace_count != TC_FULL) begin
                trace_count <= trace_count + TC_ONE;
              end else begin
                overflow <= 1'b1;
              end
              if (change_count != '1) begin
                change_count <= change_count + CNT_ONE;
              end
              prev_pc    <= pc;
              stable_cnt <= '0;
              halted     <= 1'b0;
              state      <= RUN;
            end else if (state == RUN) begin
              // In HALTED the count is frozen at HALT_CYCLES.
              stable_cnt <= stable_nxt;
              if (stable_nxt == ST_HALT) begin
                state   <= HALTED;
                halted  <= 1'b1;
                halt_pc <= pc;
              end
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
